// File: rtl/am_align_ctrl_rx.sv
// Multi-lane RX alignment controller.
// Waits for lite lock on every physical lane and measures the AM arrival skew across lanes.
// It then checks that the reported logical lane IDs form a permutation.
// Outputs per-lane deskew delays, a latched lane map and align status.
// Optional build macro AM_ALIGN_STATS_EN adds a saturating realign event counter (realign_cnt_o).
module am_align_ctrl_rx #(
    parameter int unsigned LANE_N   = 4,
    parameter int unsigned MAX_SKEW = 31,
    parameter int unsigned SKEW_W   = $clog2(MAX_SKEW + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic [LANE_N-1:0]          lite_lock_v_i,
    input  logic [LANE_N-1:0]          lite_am_v_i,
    input  logic [LANE_N*LANE_N-1:0]   lane_i,
    output logic                       align_v_o,
    output logic                       realign_o,
    output logic [LANE_N*SKEW_W-1:0]   delay_o,
`ifdef AM_ALIGN_STATS_EN
    output logic [15:0]                realign_cnt_o,
`endif
    output logic [LANE_N*LANE_N-1:0]   lane_map_o
);

    localparam logic [SKEW_W-1:0] MaxCnt = SKEW_W'(MAX_SKEW);

    typedef enum logic [4:0] {
        StIdle    = 5'b00001,
        StWaitAm  = 5'b00010,
        StCollect = 5'b00100,
        StCheck   = 5'b01000,
        StAligned = 5'b10000
    } state_e;

    state_e state_q, state_d;

    logic [SKEW_W-1:0]             cnt_q, cnt_d;
    logic [LANE_N-1:0]             seen_q, seen_d;
    // Reference arrival offsets from the acquisition pass
    logic [LANE_N-1:0][SKEW_W-1:0] arr_q, arr_d;
    // Offsets of the AM set currently being re-measured while aligned
    logic [LANE_N-1:0][SKEW_W-1:0] meas_arr_q, meas_arr_d;
    logic                          meas_q, meas_d;
    logic [LANE_N-1:0][SKEW_W-1:0] delay_q, delay_d;
    logic [LANE_N*LANE_N-1:0]      map_q, map_d;
    logic                          realign_q, realign_d;

    logic                          all_locked;
    logic                          perm_ok;
    logic [LANE_N-1:0][SKEW_W-1:0] delay_calc;

    assign all_locked = &lite_lock_v_i;

    // Lane ID check: every slice one-hot and together they cover every logical lane
    always_comb begin
        logic [LANE_N-1:0] slice;
        logic [LANE_N-1:0] lane_or;
        logic              slice_ok;
        slice    = '0;
        lane_or  = '0;
        slice_ok = 1'b1;
        for (int unsigned p = 0; p < LANE_N; p++) begin
            slice   = lane_i[p*LANE_N +: LANE_N];
            lane_or = lane_or | slice;
            if (slice == '0 || (slice & (slice - 1'b1)) != '0) begin
                slice_ok = 1'b0;
            end
        end
        perm_ok = slice_ok && (&lane_or);
    end

    // Deskew delays: latest arriving lane gets zero, the others wait for it
    always_comb begin
        logic [SKEW_W-1:0] max_arr;
        max_arr = '0;
        for (int unsigned p = 0; p < LANE_N; p++) begin
            if (arr_q[p] > max_arr) begin
                max_arr = arr_q[p];
            end
        end
        for (int unsigned p = 0; p < LANE_N; p++) begin
            delay_calc[p] = max_arr - arr_q[p];
        end
    end

    // Next-state logic; nothing advances on cycles without valid_i
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        arr_d      = arr_q;
        meas_arr_d = meas_arr_q;
        meas_d     = meas_q;
        delay_d    = delay_q;
        map_d      = map_q;
        realign_d  = 1'b0;

        if (valid_i) begin
            if (state_q != StIdle && !all_locked) begin
                // Lock loss overrides everything; only a loss of alignment is reported
                state_d   = StIdle;
                realign_d = (state_q == StAligned);
                meas_d    = 1'b0;
                seen_d    = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        seen_d = '0;
                        if (all_locked) begin
                            state_d = StWaitAm;
                        end
                    end

                    StWaitAm: begin
                        if (|lite_am_v_i) begin
                            cnt_d  = '0;
                            seen_d = lite_am_v_i;
                            for (int unsigned p = 0; p < LANE_N; p++) begin
                                if (lite_am_v_i[p]) begin
                                    arr_d[p] = '0;
                                end
                            end
                            state_d = (&lite_am_v_i) ? StCheck : StCollect;
                        end
                    end

                    StCollect: begin
                        if (cnt_q == MaxCnt) begin
                            // Spread exceeds the tolerated skew
                            state_d   = StWaitAm;
                            realign_d = 1'b1;
                            seen_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            for (int unsigned p = 0; p < LANE_N; p++) begin
                                if (lite_am_v_i[p] && !seen_q[p]) begin
                                    arr_d[p] = cnt_q + 1'b1;
                                end
                            end
                            seen_d = seen_q | lite_am_v_i;
                            if (&seen_d) begin
                                state_d = StCheck;
                            end
                        end
                    end

                    StCheck: begin
                        seen_d = '0;
                        meas_d = 1'b0;
                        if (perm_ok) begin
                            state_d = StAligned;
                            map_d   = lane_i;
                            delay_d = delay_calc;
                        end else begin
                            state_d   = StWaitAm;
                            realign_d = 1'b1;
                        end
                    end

                    StAligned: begin
                        if (!meas_q) begin
                            if (|lite_am_v_i) begin
                                cnt_d  = '0;
                                seen_d = lite_am_v_i;
                                for (int unsigned p = 0; p < LANE_N; p++) begin
                                    if (lite_am_v_i[p]) begin
                                        meas_arr_d[p] = '0;
                                    end
                                end
                                if (&lite_am_v_i) begin
                                    seen_d = '0;
                                    if (meas_arr_d != arr_q) begin
                                        state_d   = StWaitAm;
                                        realign_d = 1'b1;
                                    end
                                end else begin
                                    meas_d = 1'b1;
                                end
                            end
                        end else if (cnt_q == MaxCnt) begin
                            state_d   = StWaitAm;
                            realign_d = 1'b1;
                            meas_d    = 1'b0;
                            seen_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            for (int unsigned p = 0; p < LANE_N; p++) begin
                                if (lite_am_v_i[p] && !seen_q[p]) begin
                                    meas_arr_d[p] = cnt_q + 1'b1;
                                end
                            end
                            seen_d = seen_q | lite_am_v_i;
                            if (&seen_d) begin
                                meas_d = 1'b0;
                                seen_d = '0;
                                if (meas_arr_d != arr_q) begin
                                    state_d   = StWaitAm;
                                    realign_d = 1'b1;
                                end
                            end
                        end
                    end

                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            seen_q     <= '0;
            arr_q      <= '0;
            meas_arr_q <= '0;
            meas_q     <= 1'b0;
            delay_q    <= '0;
            map_q      <= '0;
            realign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            arr_q      <= arr_d;
            meas_arr_q <= meas_arr_d;
            meas_q     <= meas_d;
            delay_q    <= delay_d;
            map_q      <= map_d;
            realign_q  <= realign_d;
        end
    end

    assign align_v_o  = (state_q == StAligned);
    assign realign_o  = realign_q;
    assign delay_o    = delay_q;
    assign lane_map_o = map_q;

`ifdef AM_ALIGN_STATS_EN
    logic [15:0] realign_cnt_q;

    // Saturating count of realign pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            realign_cnt_q <= '0;
        end else if (realign_q && realign_cnt_q != 16'hffff) begin
            realign_cnt_q <= realign_cnt_q + 16'd1;
        end
    end

    assign realign_cnt_o = realign_cnt_q;
`endif

endmodule

// File: tb/tb_am_align_ctrl_rx.sv
// Directed self-checking bench for am_align_ctrl_rx (LANE_N=4, MAX_SKEW=31).
module tb_am_align_ctrl_rx;

    localparam int unsigned LaneN  = 4;
    localparam int unsigned SkewW  = 5;

    localparam logic [19:0] DlyRef   = {5'd5, 5'd0, 5'd4, 5'd7};
    localparam logic [15:0] MapIdent = 16'h8421;
    localparam logic [15:0] MapBad   = 16'h8422;
    localparam logic [15:0] MapScram = 16'h4281;

    logic                     clk;
    logic                     reset;
    logic                     valid_i;
    logic [LaneN-1:0]         lite_lock_v_i;
    logic [LaneN-1:0]         lite_am_v_i;
    logic [LaneN*LaneN-1:0]   lane_i;
    logic                     align_v_o;
    logic                     realign_o;
    logic [LaneN*SkewW-1:0]   delay_o;
    logic [LaneN*LaneN-1:0]   lane_map_o;
`ifdef AM_ALIGN_STATS_EN
    logic [15:0]              realign_cnt_o;
`endif

    int n_cmp;
    int n_err;

    am_align_ctrl_rx dut (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .lite_lock_v_i (lite_lock_v_i),
        .lite_am_v_i   (lite_am_v_i),
        .lane_i        (lane_i),
        .align_v_o     (align_v_o),
        .realign_o     (realign_o),
        .delay_o       (delay_o),
`ifdef AM_ALIGN_STATS_EN
        .realign_cnt_o (realign_cnt_o),
`endif
        .lane_map_o    (lane_map_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then one locked cycle so the FSM sits in WAIT_AM
    task automatic go_wait_am();
        reset       = 1'b1;
        valid_i     = 1'b1;
        lite_am_v_i = '0;
        lite_lock_v_i = 4'hf;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Drive one AM set (offset <0 = lane never sends); optional 2-cycle valid gap after offset gap_k
    task automatic run_set(input int off[4], input int gap_k, output int pulses);
        int maxk;
        maxk   = 0;
        pulses = 0;
        for (int p = 0; p < 4; p++) if (off[p] > maxk) maxk = off[p];
        for (int k = 0; k <= maxk; k++) begin
            for (int p = 0; p < 4; p++) lite_am_v_i[p] = (off[p] == k);
            valid_i = 1'b1;
            tick();
            pulses += int'(realign_o);
            if (k == gap_k) begin
                lite_am_v_i = '0;
                valid_i     = 1'b0;
                tick();
                pulses += int'(realign_o);
                tick();
                pulses += int'(realign_o);
                valid_i = 1'b1;
            end
        end
        lite_am_v_i = '0;
        tick();
        pulses += int'(realign_o);
        tick();
        pulses += int'(realign_o);
    endtask

    initial begin
        int pulses;
        int off_ref[4];
        int off_drift[4];
        int first_pulse;
        int n_pulse;
        logic align_seen;

        n_cmp = 0;
        n_err = 0;
        off_ref   = '{0, 3, 7, 2};
        off_drift = '{0, 4, 7, 2};
        lane_i    = MapIdent;

        // Reset state
        go_wait_am();
        check_eq("rst_align", 64'(align_v_o), 64'd0);
        check_eq("rst_realign", 64'(realign_o), 64'd0);
        check_eq("rst_delay", 64'(delay_o), 64'd0);
        check_eq("rst_map", 64'(lane_map_o), 64'd0);

        // Lock and skew, with an explicit look at the CHECK cycle
        for (int k = 0; k <= 7; k++) begin
            for (int p = 0; p < 4; p++) lite_am_v_i[p] = (off_ref[p] == k);
            tick();
        end
        lite_am_v_i = '0;
        check_eq("skew_align_in_check", 64'(align_v_o), 64'd0);
        tick();
        tick();
        tick();
        check_eq("skew_align", 64'(align_v_o), 64'd1);
        check_eq("skew_delay", 64'(delay_o), 64'(DlyRef));
        check_eq("skew_map", 64'(lane_map_o), 64'(MapIdent));

        // Matching re-measurement keeps alignment
        run_set(off_ref, -1, pulses);
        check_eq("match_align", 64'(align_v_o), 64'd1);
        check_eq("match_pulses", 64'(pulses), 64'd0);
        check_eq("match_delay", 64'(delay_o), 64'(DlyRef));

        // Skew drift on lane 1
        run_set(off_drift, -1, pulses);
        check_eq("drift_align", 64'(align_v_o), 64'd0);
        check_eq("drift_pulses", 64'(pulses), 64'd1);

        // Realign, then lose lock on lane 2 for one cycle
        run_set(off_ref, -1, pulses);
        check_eq("relock_align", 64'(align_v_o), 64'd1);
        lite_lock_v_i = 4'b1011;
        tick();
        lite_lock_v_i = 4'hf;
        check_eq("loss_align", 64'(align_v_o), 64'd0);
        check_eq("loss_realign", 64'(realign_o), 64'd1);
        tick();
        check_eq("loss_single_pulse", 64'(realign_o), 64'd0);
        run_set(off_ref, -1, pulses);
        check_eq("loss_recover_align", 64'(align_v_o), 64'd1);
        check_eq("loss_recover_pulses", 64'(pulses), 64'd0);

        // Timeout: lane 3 never sends an AM
        go_wait_am();
        first_pulse = -1;
        n_pulse     = 0;
        align_seen  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            lite_am_v_i = (n < 3) ? 4'(1 << n) : 4'b0000;
            tick();
            if (realign_o) begin
                n_pulse++;
                if (first_pulse < 0) first_pulse = n;
            end
            align_seen |= align_v_o;
        end
        lite_am_v_i = '0;
        check_eq("timeout_window", 64'(first_pulse >= 31 && first_pulse <= 33), 64'd1);
        check_eq("timeout_one_pulse", 64'(n_pulse), 64'd1);
        check_eq("timeout_no_align", 64'(align_seen), 64'd0);
        // FSM back in WAIT_AM: an AM on lane 0 in the very next cycle is accepted
        run_set(off_ref, -1, pulses);
        check_eq("timeout_then_align", 64'(align_v_o), 64'd1);

        // Bad permutation, then a scrambled valid one
        go_wait_am();
        lane_i = MapBad;
        run_set(off_ref, -1, pulses);
        check_eq("badperm_align", 64'(align_v_o), 64'd0);
        check_eq("badperm_pulses", 64'(pulses), 64'd1);
        lane_i = MapScram;
        run_set(off_ref, -1, pulses);
        check_eq("scram_align", 64'(align_v_o), 64'd1);
        check_eq("scram_map", 64'(lane_map_o), 64'(MapScram));
        lane_i = MapIdent;

        // Valid gaps inside COLLECT leave the measured delays unchanged
        go_wait_am();
        run_set(off_ref, 1, pulses);
        check_eq("gap_align", 64'(align_v_o), 64'd1);
        check_eq("gap_delay", 64'(delay_o), 64'(DlyRef));
        check_eq("gap_pulses", 64'(pulses), 64'd0);

        // Reset while in COLLECT
        go_wait_am();
        lite_am_v_i = 4'b0001;
        tick();
        lite_am_v_i = 4'b1000;
        tick();
        lite_am_v_i = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_collect_align", 64'(align_v_o), 64'd0);
        check_eq("rst_collect_realign", 64'(realign_o), 64'd0);

        // Reset while in ALIGNED
        go_wait_am();
        run_set(off_ref, -1, pulses);
        check_eq("pre_rst_aligned", 64'(align_v_o), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_aligned_align", 64'(align_v_o), 64'd0);
        check_eq("rst_aligned_delay", 64'(delay_o), 64'd0);
        check_eq("rst_aligned_map", 64'(lane_map_o), 64'd0);
        check_eq("rst_aligned_realign", 64'(realign_o), 64'd0);

`ifdef AM_ALIGN_STATS_EN
        // Three forced loss events
        go_wait_am();
        for (int i = 0; i < 3; i++) begin
            run_set(off_ref, -1, pulses);
            lite_lock_v_i = 4'b1101;
            tick();
            lite_lock_v_i = 4'hf;
            tick();
        end
        tick();
        check_eq("stats_count", 64'(realign_cnt_o), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
